// File: rtl/bit_serial_alu_ctrl_if.sv
// Command/result bus between a requester and bit_serial_alu_ctrl.
//   master : drives start/cmd/a/b, observes ready/done/err/result/flags
//   slave  : the sequencer side
interface bit_serial_alu_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             ovf;
  logic             parity;

  modport master (
    output start, cmd, a, b,
    input  ready, done, err, result, carry_out, ovf, parity
  );

  modport slave (
    input  start, cmd, a, b,
    output ready, done, err, result, carry_out, ovf, parity
  );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer around a 1-bit ALU slice. Accepts a WIDTH-bit operand
// pair and a command, presents one operand bit per clock (LSB first) to the
// slice, gathers the slice result bits and reports carry, signed overflow and
// even parity. The ripple carry is generated here; the slice returns only the
// per-bit result.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bus (slave)       start/cmd/a/b in; ready/done/err/result/carry_out/ovf/parity out
//   slice_a, slice_b  current operand bits to the slice
//   slice_ainv/binv   invert controls, slice_cin carry-in, slice_op operation
//   slice_res         result bit returned by the slice
// Build option: define BIT_SERIAL_ALU_PARITY_EN to build the parity register;
// otherwise parity is tied low.
module bit_serial_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  bit_serial_alu_ctrl_if.slave bus,
  output logic                slice_a,
  output logic                slice_b,
  output logic                slice_ainv,
  output logic                slice_binv,
  output logic                slice_cin,
  output logic [1:0]          slice_op,
  input  logic                slice_res
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             ainv_q;
  logic             binv_q;
  logic [1:0]       op_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             ovf_q;

  // Command decode: invert controls, slice op and initial carry
  logic       dec_legal;
  logic       dec_ainv;
  logic       dec_binv;
  logic [1:0] dec_op;
  logic       dec_cin;

  always_comb begin
    dec_legal = 1'b1;
    dec_ainv  = 1'b0;
    dec_binv  = 1'b0;
    dec_op    = 2'b00;
    dec_cin   = 1'b0;
    case (bus.cmd)
      3'b000: ;
      3'b001: dec_op = 2'b01;
      3'b010: dec_op = 2'b10;
      3'b011: begin
        dec_binv = 1'b1;
        dec_op   = 2'b10;
        dec_cin  = 1'b1;
      end
      3'b100: begin
        dec_ainv = 1'b1;
        dec_binv = 1'b1;
      end
      3'b101: begin
        dec_ainv = 1'b1;
        dec_binv = 1'b1;
        dec_op   = 2'b01;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Ripple carry from the post-invert operand bits; slice supplies only the sum
  logic             a_bit;
  logic             b_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             arith;

  assign a_bit     = a_sh[0] ^ ainv_q;
  assign b_bit     = b_sh[0] ^ binv_q;
  assign carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
  assign res_nxt   = {slice_res, res_sh};
  assign arith     = (op_q == 2'b10);

`ifdef BIT_SERIAL_ALU_PARITY_EN
  logic parity_q;
`endif

  // Sequencer state, shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      cnt         <= '0;
      carry_q     <= 1'b0;
      ainv_q      <= 1'b0;
      binv_q      <= 1'b0;
      op_q        <= 2'b00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef BIT_SERIAL_ALU_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (dec_legal) begin
              a_sh    <= bus.a;
              b_sh    <= bus.b;
              ainv_q  <= dec_ainv;
              binv_q  <= dec_binv;
              op_q    <= dec_op;
              carry_q <= dec_cin;
              cnt     <= '0;
              state_q <= RUN;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_nxt[WIDTH-1:1];
          carry_q <= carry_nxt;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            result_q    <= res_nxt;
            // carry_q here is the carry into the MSB
            carry_out_q <= arith & carry_nxt;
            ovf_q       <= arith & (carry_q ^ carry_nxt);
`ifdef BIT_SERIAL_ALU_PARITY_EN
            parity_q    <= ^res_nxt;
`endif
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slice drive is live only while running
  logic run;
  assign run        = (state_q == RUN);
  assign slice_a    = run & a_sh[0];
  assign slice_b    = run & b_sh[0];
  assign slice_ainv = run & ainv_q;
  assign slice_binv = run & binv_q;
  assign slice_cin  = run & carry_q;
  assign slice_op   = run ? op_q : 2'b00;

  assign bus.ready     = (state_q == IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.ovf       = ovf_q;
`ifdef BIT_SERIAL_ALU_PARITY_EN
  assign bus.parity    = parity_q;
`else
  assign bus.parity    = 1'b0;
`endif

endmodule

// File: doc/bit_serial_alu_ctrl.md
# bit_serial_alu_ctrl

Bit-serial sequencer wrapped around the team's 1-bit ALU slice.
- Accepts a WIDTH-bit operand pair and a command, then drives the slice one bit per clock, LSB first.
- Collects the slice result bits into a WIDTH-bit word and reports carry, signed overflow and an even-parity bit.
- Sits directly upstream and downstream of the slice: it feeds the slice's inputs and consumes its result.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  command request, sampled only when ready=1
- cmd  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 NOR, 101 NAND, 110/111 illegal
- a, b  in  WIDTH  operands, sampled on the accepting edge
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse, result fields valid
- err  out  1  with done, illegal cmd
- result  out  WIDTH  registered result, held until next done
- carry_out  out  1  final carry (ADD/SUB), 0 for logic ops
- ovf  out  1  signed overflow (ADD/SUB), 0 for logic ops
- parity  out  1  even-parity bit of result (XOR of all result bits)
- slice_a, slice_b  out  1  current operand bits to slice
- slice_ainv, slice_binv, slice_cin  out  1  invert controls / carry-in to slice
- slice_op  out  2  slice operation select, never 2'b11
- slice_res  in  1  slice Result bit

## Operation
- States: IDLE, RUN, DONE.
- Command decode (ainv, binv, op, initial carry):
  - AND: 0,0,00,0
  - OR: 0,0,01,0
  - ADD: 0,0,10,0
  - SUB: 0,1,10,1
  - NOR: 1,1,00,0
  - NAND: 1,1,01,0
- IDLE + start, legal cmd:
  - Latch a, b into shift registers.
  - Latch decoded controls and set carry to its initial value; set cnt=0.
  - Go to RUN.
- IDLE + start, illegal cmd: go to DONE with err flag set; result, carry_out, ovf and parity keep their previous values.
- RUN, each cycle:
  - slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry; slice_ainv, slice_binv and slice_op come from the latched controls.
  - On the edge: shift slice_res into the MSB of res_sh and shift right; shift a_sh and b_sh right.
  - Update carry to majority(a', b', carry), where a'/b' are the post-invert bits. The slice returns only the mod-2 sum, so the controller generates the ripple carry itself.
  - cnt++.
- RUN with cnt==WIDTH-1: on that edge, load result←final res_sh, carry_out←new carry, and ovf←(carry into MSB)^(carry out of MSB). Go to DONE. carry_out and ovf are forced to 0 for logic ops.
- DONE: done=1 for one cycle, then IDLE.
- parity: XOR-reduce of result, registered with result.
- Outside RUN, all slice_* outputs are 0 (slice_op=00).
- start while ready=0 is ignored, with no queuing.
- Reset value of all registered outputs is 0. ready=1 from the first cycle after reset.
- rst mid-RUN or in DONE aborts: no done pulse, state IDLE, all outputs cleared.

## Timing
- start accepted at edge k → RUN during cycles k+1…k+WIDTH → done high in cycle k+WIDTH+1 → ready high in cycle k+WIDTH+2.
- Throughput: one command per WIDTH+2 cycles.
- Illegal cmd: done=err=1 in cycle k+1.
- Slice path is combinational, so slice_res is sampled on the same edge the bit is presented.
- result, carry_out, ovf and parity change only on the edge entering DONE, and are stable from done until the next done.

## Configuration
- BIT_SERIAL_ALU_PARITY_EN:
  - Defined: parity register and XOR-reduce are built, and parity behaves as described under Operation.
  - Undefined: parity is tied to 0 and no parity logic is synthesized.
  - All other outputs are identical in both builds.

## Test plan
All scenarios use WIDTH=8, with the bench instantiating the 1-bit slice on the slice_* ports.
- ADD a=0x7F, b=0x01 → done at k+9; result=0x80, carry_out=0, ovf=1, parity=1.
- SUB a=0x05, b=0x07 → result=0xFE, carry_out=0, ovf=0, parity=1. ADD 0xFF+0x01 → result=0x00, carry_out=1, ovf=0, parity=0.
- AND 0xF0,0x3C → 0x30, parity=0. NOR 0x0F,0xF0 → 0x00. NAND 0xFF,0x0F → 0xF0. carry_out=ovf=0 for all three.
- cmd=110 → done=err=1 at k+1; result unchanged from the previous command. slice_op is never 11 at any time.
- start pulsed during RUN → ignored, and the first command completes unchanged. rst at cycle k+4 → no done, ready=1 next cycle, outputs 0.
- Build without BIT_SERIAL_ALU_PARITY_EN → parity=0 for ADD 0x7F+0x01, all other outputs identical.
